data_ram_ctrl: RTL and testbench
================================

# data_ram_ctrl

Clocked, parametrised successor to the 256x8 data memory. It is a byte-addressable, big-endian RAM behind a request/done handshake with configurable wait states, optional sign extension on loads, and alignment/range fault reporting. It sits on the CPU's MEM stage and is the data store the pipeline stalls on via `Busy`.

## Interface
Parameters:
- `DEPTH`, 256: number of byte locations in `Mem[0:DEPTH-1]`.
- `ADDR_W`, 32: width of `Address`.
- `WAIT_CYCLES`, 1: extra cycles between request capture and memory commit (0 is legal).

Ports:
- `Clk`  in  1  sole clock; all state changes on posedge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  request strobe; sampled only in IDLE.
- `ReadWrite`  in  1  0 = read, 1 = write.
- `Address`  in  ADDR_W  byte address of the most significant byte.
- `DataIn`  in  32  write data, right-justified.
- `Size`  in  2  00 byte, 01 half-word, 10 word, 11 illegal.
- `Signed`  in  1  reads only: 1 sign-extends byte/half, 0 zero-extends.
- `DataOut`  out  32  read data, right-justified, held until the next successful read.
- `Busy`  out  1  high while a request is in flight (state != IDLE).
- `Done`  out  1  one-cycle completion pulse.
- `Fault`  out  1  valid with `Done`; 1 = request rejected.

## Operation
- States:
  - IDLE → WAIT on `Enable`=1. Capture `Address`, `DataIn`, `Size`, `ReadWrite`, `Signed`, and load the counter with `WAIT_CYCLES`.
  - WAIT decrements the counter. When the counter is 0, perform the access and go to RESP.
  - RESP asserts `Done` and returns to IDLE.
  - With `WAIT_CYCLES`=0, WAIT lasts exactly one cycle.
- Fault check at capture:
  - `Size`=11 faults.
  - Half-word with `Address[0]`≠0 faults.
  - Word with `Address[1:0]`≠0 faults.
  - Out of range (`Address`+nbytes > `DEPTH`) faults.
  - A faulting request still traverses WAIT/RESP. No memory write occurs, `DataOut` is unchanged, and `Fault`=1 with `Done`.
- Big-endian byte order: `Mem[A]` is the MSB.
  - Write half: `Mem[A]`=`DataIn[15:8]`, `Mem[A+1]`=`DataIn[7:0]`.
  - Write word: `DataIn[31:24]`..`[7:0]` go to `A`..`A+3`.
  - Write byte: `DataIn[7:0]`.
- Reads:
  - Byte: `{ext24, Mem[A]}`.
  - Half: `{ext16, Mem[A], Mem[A+1]}`.
  - Word: four bytes concatenated.
  - `ext` is the replicated MSB when `Signed`=1, zeros otherwise.
- Writes do not modify `DataOut`.
- `Enable` while `Busy` is ignored, never queued. Holding `Enable` high issues a new request on the first IDLE cycle.

## Timing
- Reset (async assert, any state):
  - State IDLE, counter 0.
  - `Busy`=0, `Done`=0, `Fault`=0, `DataOut`=32'h0.
  - `Mem` contents are not reset.
- Latency: request sampled at edge N. Commit happens at edge N+1+`WAIT_CYCLES`. `Done`/`Fault` are high for the cycle after that edge, and the read `DataOut` is valid in the same cycle.
- `Busy` rises after edge N and falls after the edge that ends RESP. The earliest next request is sampled at edge N+3+`WAIT_CYCLES`.
- A write commits at a single edge, so the access is atomic. Reset before the commit edge leaves `Mem` untouched.
- `Address` wrap beyond `DEPTH` is never performed. It is reported as a fault.

## Structure
- Shared package `data_mem_pkg`:
  - Size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
  - State enum `IDLE`/`WAIT`/`RESP`.
  - Byte-count function.
- One combinational sub-module, `data_mem_lane`. It takes the captured size, signed flag, address, and `Mem` bytes, and produces the read word plus the fault flag.
- The `Mem` array is named `Mem` so benches can preload it hierarchically.

## Test plan
- Preload `Mem[0..3]`=E3,5D,8A,C5 with `WAIT_CYCLES`=1. Word read @0 → `Done` after edge N+2, `DataOut`=32'hE35D8AC5, `Fault`=0.
- Byte read @2 with `Signed`=1 → 32'hFFFFFF8A. The same read with `Signed`=0 → 32'h0000008A.
- Half write 16'hFFD3 @2, then word read @0 → 32'hE35DFFD3. The write itself leaves `DataOut` unchanged.
- Faulting requests, each → `Done`=1 with `Fault`=1, `Mem` unchanged, `DataOut` holds the prior value:
  - word @6 (misaligned);
  - `Size`=11 @0 (illegal size);
  - word @254 with `DEPTH`=256 (out of range).
- Word write 32'h12345678 @8, with `Reset_n` pulsed low during WAIT (`WAIT_CYCLES`=3) → `Mem[8..11]` unchanged, all outputs 0, `Busy`=0.
- Hold `Enable`=1 across two back-to-back reads @0 and @4 → the second is sampled only after `Busy` falls, exactly N+3+`WAIT_CYCLES`. Exactly two `Done` pulses occur.

Source files
------------

// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the byte-addressable data RAM controller:
// access-size encodings, controller states and the size-to-byte-count helper.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Illegal size maps to zero bytes; it is rejected separately by the fault logic.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/done bus of the data RAM controller; signal names match the
// controller's ports so a bench or CPU can wire them one-to-one.
interface data_ram_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              Enable;
  logic              ReadWrite;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [1:0]        Size;
  logic              Signed;
  logic [31:0]       DataOut;
  logic              Busy;
  logic              Done;
  logic              Fault;

  modport master (
    output Enable, ReadWrite, Address, DataIn, Size, Signed,
    input  DataOut, Busy, Done, Fault
  );

  modport slave (
    input  Enable, ReadWrite, Address, DataIn, Size, Signed,
    output DataOut, Busy, Done, Fault
  );

endinterface

// File: rtl/data_ram_ctrl_lane.sv
// Combinational lane logic: turns the captured request and the four
// big-endian bytes at the request address into read data and a fault flag.
module data_mem_lane
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_bytes,
  output logic [31:0]       o_rdata,
  output logic              o_fault
);

  logic [ADDR_W:0] w_end;
  logic            w_range;
  logic            w_shape_bad;

  // One extra bit so an address near the top of the space cannot wrap into range.
  assign w_end   = {1'b0, i_addr} + (ADDR_W+1)'(size_nbytes(i_size));
  assign w_range = (w_end > (ADDR_W+1)'(DEPTH));

  always_comb begin
    w_shape_bad = 1'b0;
    case (i_size)
      SIZE_HALF: w_shape_bad = i_addr[0];
      SIZE_WORD: w_shape_bad = |i_addr[1:0];
      SIZE_ILL:  w_shape_bad = 1'b1;
      default:   w_shape_bad = 1'b0;
    endcase
  end

  assign o_fault = w_shape_bad | w_range;

  always_comb begin
    o_rdata = '0;
    case (i_size)
      SIZE_BYTE: o_rdata = {{24{i_signed & i_bytes[31]}}, i_bytes[31:24]};
      SIZE_HALF: o_rdata = {{16{i_signed & i_bytes[31]}}, i_bytes[31:16]};
      SIZE_WORD: o_rdata = i_bytes;
      default:   o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Big-endian byte-addressable data RAM behind a request/done handshake with
// configurable wait states, load sign extension and alignment/range faults.
module data_ram_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic [1:0]        Size,
  input  logic              Signed,
  output logic [31:0]       DataOut,
  output logic              Busy,
  output logic              Done,
  output logic              Fault
);

  localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int unsigned IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [7:0] Mem [0:DEPTH-1];

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_capture;
  logic              w_commit;

  logic              r_rw;
  logic              r_signed;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic [31:0]       r_dout;
  logic              r_fault;

  logic [IDX_W-1:0]  w_idx [4];
  logic [31:0]       w_bytes;
  logic [31:0]       w_rdata;
  logic              w_fault;

  // Bytes past the end of the array read as zero; such requests fault anyway.
  always_comb begin
    w_bytes = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx[k] = IDX_W'(r_addr) + IDX_W'(k);
      if (({1'b0, r_addr} + (ADDR_W+1)'(k)) < (ADDR_W+1)'(DEPTH))
        w_bytes[31 - 8*k -: 8] = Mem[w_idx[k]];
    end
  end

  data_mem_lane #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_lane (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_addr   (r_addr),
    .i_bytes  (w_bytes),
    .o_rdata  (w_rdata),
    .o_fault  (w_fault)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Enable) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: w_state_nxt = IDLE;
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rw     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= SIZE_BYTE;
      r_addr   <= '0;
      r_din    <= '0;
    end else if (w_capture) begin
      r_rw     <= ReadWrite;
      r_signed <= Signed;
      r_size   <= Size;
      r_addr   <= Address;
      r_din    <= DataIn;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fault <= 1'b0;
      r_dout  <= '0;
    end else if (w_commit) begin
      r_fault <= w_fault;
      if (!w_fault && !r_rw)
        r_dout <= w_rdata;
    end
  end

  // Memory contents survive reset; a write lands entirely on the commit edge.
  always_ff @(posedge Clk) begin
    if (w_commit && !w_fault && r_rw) begin
      case (r_size)
        SIZE_BYTE: Mem[w_idx[0]] <= r_din[7:0];
        SIZE_HALF: begin
          Mem[w_idx[0]] <= r_din[15:8];
          Mem[w_idx[1]] <= r_din[7:0];
        end
        SIZE_WORD: begin
          Mem[w_idx[0]] <= r_din[31:24];
          Mem[w_idx[1]] <= r_din[23:16];
          Mem[w_idx[2]] <= r_din[15:8];
          Mem[w_idx[3]] <= r_din[7:0];
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (r_state != IDLE);
  assign Done    = (r_state == RESP);
  assign Fault   = Done & r_fault;
  assign DataOut = r_dout;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: one instance with one wait state for the
// functional vectors, one with three wait states for latency and mid-request reset.
module tb_data_ram_ctrl;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n;
  logic rst3_n;

  data_ram_ctrl_if #(.ADDR_W(32)) bus1 ();
  data_ram_ctrl_if #(.ADDR_W(32)) bus3 ();

  data_ram_ctrl #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(1)) dut1 (
    .Clk       (clk),
    .Reset_n   (rst1_n),
    .Enable    (bus1.Enable),
    .ReadWrite (bus1.ReadWrite),
    .Address   (bus1.Address),
    .DataIn    (bus1.DataIn),
    .Size      (bus1.Size),
    .Signed    (bus1.Signed),
    .DataOut   (bus1.DataOut),
    .Busy      (bus1.Busy),
    .Done      (bus1.Done),
    .Fault     (bus1.Fault)
  );

  data_ram_ctrl #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
    .Clk       (clk),
    .Reset_n   (rst3_n),
    .Enable    (bus3.Enable),
    .ReadWrite (bus3.ReadWrite),
    .Address   (bus3.Address),
    .DataIn    (bus3.DataIn),
    .Size      (bus3.Size),
    .Signed    (bus3.Signed),
    .DataOut   (bus3.DataOut),
    .Busy      (bus3.Busy),
    .Done      (bus3.Done),
    .Fault     (bus3.Fault)
  );

  int n_checks = 0;
  int n_errors = 0;
  int lat3;
  int dones;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on dut1; Done is expected two edges after the sampling edge.
  task automatic xfer(input string tag, input logic rw, input logic [31:0] addr,
                      input logic [31:0] din, input logic [1:0] sz, input logic sg,
                      input logic exp_fault, input logic [31:0] exp_dout);
    int lat;
    @(negedge clk);
    bus1.ReadWrite = rw;
    bus1.Address   = addr;
    bus1.DataIn    = din;
    bus1.Size      = sz;
    bus1.Signed    = sg;
    bus1.Enable    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.Enable = 1'b0;
    check({tag, ".busy"}, bus1.Busy, 1);
    lat = 0;
    while (!bus1.Done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, ".done"}, bus1.Done, 1);
    check({tag, ".latency"}, lat, 2);
    check({tag, ".fault"}, bus1.Fault, exp_fault);
    check({tag, ".dataout"}, bus1.DataOut, exp_dout);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".idle"}, bus1.Busy, 0);
    check({tag, ".done_pulse"}, bus1.Done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    bus1.Enable = 1'b0; bus1.ReadWrite = 1'b0; bus1.Address = '0;
    bus1.DataIn = '0;   bus1.Size = SIZE_BYTE; bus1.Signed = 1'b0;
    bus3.Enable = 1'b0; bus3.ReadWrite = 1'b0; bus3.Address = '0;
    bus3.DataIn = '0;   bus3.Size = SIZE_BYTE; bus3.Signed = 1'b0;
    #22;
    check("rst.dataout", bus1.DataOut, 32'h0);
    check("rst.busy", bus1.Busy, 0);
    check("rst.done", bus1.Done, 0);
    check("rst.fault", bus1.Fault, 0);
    @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    xfer("w_word0",     1, 32'd0,   32'hE35D8AC5, SIZE_WORD, 0, 0, 32'h00000000);
    xfer("w_word4",     1, 32'd4,   32'h0BADF00D, SIZE_WORD, 0, 0, 32'h00000000);
    xfer("r_word0",     0, 32'd0,   32'h0,        SIZE_WORD, 0, 0, 32'hE35D8AC5);
    xfer("r_byte2_s",   0, 32'd2,   32'h0,        SIZE_BYTE, 1, 0, 32'hFFFFFF8A);
    xfer("r_byte2_u",   0, 32'd2,   32'h0,        SIZE_BYTE, 0, 0, 32'h0000008A);
    xfer("r_half0_s",   0, 32'd0,   32'h0,        SIZE_HALF, 1, 0, 32'hFFFFE35D);
    xfer("r_half2_u",   0, 32'd2,   32'h0,        SIZE_HALF, 0, 0, 32'h00008AC5);
    xfer("w_half2",     1, 32'd2,   32'h0000FFD3, SIZE_HALF, 0, 0, 32'h00008AC5);
    xfer("r_word0b",    0, 32'd0,   32'h0,        SIZE_WORD, 0, 0, 32'hE35DFFD3);
    xfer("w_word252",   1, 32'd252, 32'h01027EB2, SIZE_WORD, 0, 0, 32'hE35DFFD3);
    xfer("r_byte255_s", 0, 32'd255, 32'h0,        SIZE_BYTE, 1, 0, 32'hFFFFFFB2);
    xfer("r_half254_u", 0, 32'd254, 32'h0,        SIZE_HALF, 0, 0, 32'h00007EB2);
    xfer("r_word252",   0, 32'd252, 32'h0,        SIZE_WORD, 1, 0, 32'h01027EB2);

    xfer("f_mis_word6", 0, 32'd6,   32'h0,        SIZE_WORD, 0, 1, 32'h01027EB2);
    xfer("f_size11",    0, 32'd0,   32'h0,        SIZE_ILL,  0, 1, 32'h01027EB2);
    xfer("f_range254",  0, 32'd254, 32'h0,        SIZE_WORD, 0, 1, 32'h01027EB2);
    xfer("f_wr_range",  1, 32'd254, 32'hDEADBEEF, SIZE_WORD, 0, 1, 32'h01027EB2);
    check("f_wr_range.mem254", dut1.Mem[254], 32'h7E);
    check("f_wr_range.mem255", dut1.Mem[255], 32'hB2);
    xfer("f_range256",  0, 32'd256, 32'h0,        SIZE_BYTE, 0, 1, 32'h01027EB2);
    xfer("f_wrap",      0, 32'hFFFFFFFF, 32'h0,   SIZE_BYTE, 0, 1, 32'h01027EB2);
    xfer("f_wr_half3",  1, 32'd3,   32'h00001111, SIZE_HALF, 0, 1, 32'h01027EB2);
    check("f_wr_half3.mem3", dut1.Mem[3], 32'hD3);
    check("f_wr_half3.mem4", dut1.Mem[4], 32'h0B);

    // Enable held high across two reads: the second is sampled four edges after the first.
    @(negedge clk);
    bus1.ReadWrite = 1'b0;
    bus1.Address   = 32'd0;
    bus1.Size      = SIZE_WORD;
    bus1.Signed    = 1'b0;
    bus1.Enable    = 1'b1;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) bus1.Address = 32'd4;
      if (c == 4) check("b2b.idle_gap", bus1.Busy, 0);
      if (c == 5) begin
        check("b2b.second_sample", bus1.Busy, 1);
        bus1.Enable = 1'b0;
      end
      if (bus1.Done) begin
        dones++;
        if (dones == 1) begin
          check("b2b.first_at", c, 3);
          check("b2b.first_data", bus1.DataOut, 32'hE35DFFD3);
        end else if (dones == 2) begin
          check("b2b.second_at", c, 7);
          check("b2b.second_data", bus1.DataOut, 32'h0BADF00D);
        end
      end
    end
    check("b2b.done_count", dones, 2);

    // Three wait states: known word first, then an interrupted overwrite.
    @(negedge clk);
    bus3.ReadWrite = 1'b1;
    bus3.Address   = 32'd8;
    bus3.DataIn    = 32'hA5A5A5A5;
    bus3.Size      = SIZE_WORD;
    bus3.Enable    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.Enable = 1'b0;
    lat3 = 0;
    while (!bus3.Done && lat3 < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat3++;
    end
    check("w3.done", bus3.Done, 1);
    check("w3.latency", lat3, 4);
    check("w3.fault", bus3.Fault, 0);
    @(posedge clk);
    @(negedge clk);
    bus3.DataIn = 32'h12345678;
    bus3.Enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.Enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst3.in_wait", bus3.Busy, 1);
    rst3_n = 1'b0;
    #1;
    check("rst3.busy", bus3.Busy, 0);
    check("rst3.done", bus3.Done, 0);
    check("rst3.fault", bus3.Fault, 0);
    check("rst3.dataout", bus3.DataOut, 32'h0);
    @(negedge clk);
    rst3_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus3.Done) dones++;
    end
    check("rst3.no_done", dones, 0);
    check("rst3.idle", bus3.Busy, 0);
    check("rst3.mem8",  dut3.Mem[8],  32'hA5);
    check("rst3.mem9",  dut3.Mem[9],  32'hA5);
    check("rst3.mem10", dut3.Mem[10], 32'hA5);
    check("rst3.mem11", dut3.Mem[11], 32'hA5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
